// File: rtl/prime_sched_pkg.sv
// Shared types and constants for the nth-prime job scheduler.
package prime_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  localparam int unsigned MAX_N_DEFAULT = 1000;

  localparam logic RSP_ERR_NONE = 1'b0;
  localparam logic RSP_ERR_FAIL = 1'b1;

endpackage

// File: rtl/prime_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module prime_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [IW-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      sel = IW'((int'(ptr) + k) % int'(NREQ));
      if (!grant_any && req[sel]) begin
        grant_any  = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/prime_job_scheduler.sv
// Shares one nth-prime engine among NREQ requesters with a one-entry result cache.
// Optional engine watchdog enabled by defining PRIME_SCHED_TIMEOUT_EN.
module prime_job_scheduler
  import prime_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NW      = 16,
  parameter int unsigned MAX_N   = MAX_N_DEFAULT,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*NW-1:0]   req_n,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_prime,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [NW-1:0]        eng_n,
  output logic                 eng_abort,
  input  logic                 eng_done,
  input  logic [31:0]          eng_result,
  output logic                 sched_busy,
  output logic [31:0]          jobs_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NW-1:0] MAX_N_W = NW'(MAX_N);

  sched_state_t state, state_next;

  logic [IW-1:0]   rr_ptr, cur_id, grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [NW-1:0]   cur_n, cache_n, granted_n;
  logic [31:0]     cache_p;
  logic            cache_valid;
  logic            take_req, chk_err, chk_hit, eng_fin, timeout_hit, accept;

  prime_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign granted_n = req_n[grant_idx*NW +: NW];

`ifdef PRIME_SCHED_TIMEOUT_EN
  // Counts cycles spent in WAIT; a done in the same cycle as expiry takes priority.
  logic [31:0] wait_cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)           wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 32'd1;
    else                    wait_cnt <= '0;
  end

  assign timeout_hit = (state == WAIT) && !eng_done && (wait_cnt == 32'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  assign eng_abort = timeout_hit;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_req   = 1'b0;
    chk_err    = 1'b0;
    chk_hit    = 1'b0;
    eng_fin    = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: if (grant_any) begin
        take_req   = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        if (cur_n == '0 || cur_n > MAX_N_W) begin
          chk_err    = 1'b1;
          state_next = RESP;
        end else if (cache_valid && cache_n == cur_n) begin
          chk_hit    = 1'b1;
          state_next = RESP;
        end else begin
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          eng_fin    = 1'b1;
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: if (rsp_ready[cur_id]) begin
        accept     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job context, response registers, cache and round-robin pointer.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cur_id      <= '0;
      cur_n       <= '0;
      rsp_prime   <= '0;
      rsp_err     <= RSP_ERR_NONE;
      cache_valid <= 1'b0;
      cache_n     <= '0;
      cache_p     <= '0;
      jobs_done   <= '0;
      rr_ptr      <= '0;
    end else begin
      if (take_req) begin
        cur_id <= grant_idx;
        cur_n  <= granted_n;
      end
      if (chk_err || timeout_hit) begin
        rsp_prime <= '0;
        rsp_err   <= RSP_ERR_FAIL;
      end else if (chk_hit) begin
        rsp_prime <= cache_p;
        rsp_err   <= RSP_ERR_NONE;
      end else if (eng_fin) begin
        rsp_prime   <= eng_result;
        rsp_err     <= RSP_ERR_NONE;
        cache_valid <= 1'b1;
        cache_n     <= cur_n;
        cache_p     <= eng_result;
      end
      if (accept) begin
        jobs_done <= jobs_done + 32'd1;
        rr_ptr    <= (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
      end
    end
  end

  // Grants are withheld while reset is asserted so every output reads 0.
  assign req_ready  = (state == IDLE && n_reset) ? grant : '0;
  assign rsp_valid  = (state == RESP) ? (NREQ'(1) << cur_id) : '0;
  assign eng_start  = (state == ISSUE);
  assign eng_n      = cur_n;
  assign sched_busy = (state != IDLE);

endmodule

// File: tb/tb_prime_job_scheduler.sv
// Directed self-checking bench for prime_job_scheduler with a behavioural engine and a response scoreboard.
module tb_prime_job_scheduler;

  localparam int NREQ = 4;
  localparam int NW   = 16;

  logic                clk = 1'b0;
  logic                n_reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*NW-1:0]  req_n;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_prime;
  logic                rsp_err;
  logic                eng_start;
  logic [NW-1:0]       eng_n;
  logic                eng_abort;
  logic                eng_done;
  logic [31:0]         eng_result;
  logic                sched_busy;
  logic [31:0]         jobs_done;

  always #5 clk = ~clk;

  prime_job_scheduler #(
    .NREQ(NREQ), .NW(NW), .MAX_N(1000), .TIMEOUT(20)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .req_valid  (req_valid),
    .req_n      (req_n),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_prime  (rsp_prime),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_n      (eng_n),
    .eng_abort  (eng_abort),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .sched_busy (sched_busy),
    .jobs_done  (jobs_done)
  );

  typedef struct {
    int          id;
    logic [31:0] prime;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int          start_cnt     = 0;
  int          eng_lat       = 3;
  bit          engine_mute   = 1'b0;
  logic [15:0] last_eng_n    = '0;
  int          jobs_model    = 0;
  bit          mc_valid      = 1'b0;
  logic [15:0] mc_n          = '0;
  bit          model_timeout = 1'b0;
  int          since_start   = 0;
  int          abort_at      = -1;

  function automatic bit is_prime(input int c);
    if (c < 2) return 1'b0;
    for (int d = 2; d * d <= c; d++)
      if (c % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] nth_prime(input int n);
    int cnt = 0;
    int c   = 1;
    while (cnt < n) begin
      c++;
      if (is_prime(c)) cnt++;
    end
    return 32'(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({tag, "_rsp_prime"},  rsp_prime,       32'd0);
    check({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    check({tag, "_eng_start"},  32'(eng_start),  32'd0);
    check({tag, "_eng_n"},      32'(eng_n),      32'd0);
    check({tag, "_eng_abort"},  32'(eng_abort),  32'd0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
    check({tag, "_jobs_done"},  jobs_done,       32'd0);
  endtask

  // Behavioural engine: answers eng_start after eng_lat cycles unless muted; ignores reset.
  initial begin
    logic [15:0] n_cap;
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        start_cnt++;
        n_cap      = eng_n;
        last_eng_n = eng_n;
        if (!engine_mute) begin
          repeat (eng_lat) @(negedge clk);
          eng_result = nth_prime(int'(n_cap));
          eng_done   = 1'b1;
          @(negedge clk);
          eng_done   = 1'b0;
          eng_result = '0;
        end
      end
    end
  end

  // Cycle position of eng_abort relative to the last eng_start.
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) since_start = 0;
      else                    since_start++;
      if (eng_abort === 1'b1) abort_at = since_start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Waits for a grant, predicts the response, then collects and accepts it.
  task automatic applyStimulus(input int exp_id, input int ready_delay, input bit drop);
    bit          got;
    int          gid;
    int          k;
    int          starts0;
    bit          use_engine;
    bit          stable_ok;
    logic [15:0] n;
    exp_t        e;
    logic [NREQ-1:0] v0;
    logic [31:0] p0;

    got = 1'b0;
    gid = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (req_ready !== '0) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check("grant_wait", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
    check("grant_id", 32'(gid), 32'(exp_id));
    check("grant_onehot", 32'(req_ready), 32'd1 << gid);

    n    = req_n[gid*NW +: NW];
    e.id = gid;
    if (n == 0 || n > 1000) begin
      e.prime = 0; e.err = 1'b1; use_engine = 1'b0;
    end else if (model_timeout) begin
      e.prime = 0; e.err = 1'b1; use_engine = 1'b1;
    end else if (mc_valid && mc_n == n) begin
      e.prime = nth_prime(int'(n)); e.err = 1'b0; use_engine = 1'b0;
    end else begin
      e.prime = nth_prime(int'(n)); e.err = 1'b0; use_engine = 1'b1;
      mc_valid = 1'b1; mc_n = n;
    end
    sb.push_back(e);
    starts0 = start_cnt;

    @(posedge clk);
    @(negedge clk);
    if (drop) req_valid[gid] = 1'b0;
    k   = 1;
    got = 1'b0;
    while (k < 300 && !got) begin
      #1;
      if (rsp_valid !== '0) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      check("rsp_wait", 32'd0, 32'd1);
      return;
    end
    checkOutput(sb.pop_front(), use_engine, start_cnt - starts0, k, n);

    v0 = rsp_valid;
    p0 = rsp_prime;
    stable_ok = 1'b1;
    for (int d = 0; d < ready_delay; d++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== v0 || rsp_prime !== p0) stable_ok = 1'b0;
    end
    if (ready_delay > 0) check("rsp_hold", 32'(stable_ok), 32'd1);

    rsp_ready[gid] = 1'b1;
    @(negedge clk);
    rsp_ready[gid] = 1'b0;
    jobs_model++;
    #1;
    check("jobs_done", jobs_done, 32'(jobs_model));
    check("rsp_cleared", 32'(rsp_valid), 32'd0);
  endtask

  task automatic checkOutput(input exp_t e, input bit use_engine, input int starts,
                             input int latency, input logic [15:0] n);
    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
    check("rsp_prime", rsp_prime, e.prime);
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    check("eng_starts", 32'(starts), 32'(use_engine));
    if (use_engine) check("eng_n", 32'(last_eng_n), 32'(n));
    else            check("fast_latency", 32'(latency), 32'd2);
  endtask

  initial begin
    bit bad;
    n_reset   = 1'b0;
    req_valid = '0;
    req_n     = '0;
    rsp_ready = '0;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    n_reset = 1'b1;

    $display("[TB] single request n=1");
    @(negedge clk);
    req_n[1*NW +: NW] = 16'd1;
    req_valid[1] = 1'b1;
    applyStimulus(1, 0, 1'b1);

    $display("[TB] illegal n values");
    req_n[0*NW +: NW] = 16'd0;
    req_valid[0] = 1'b1;
    applyStimulus(0, 0, 1'b1);
    req_n[0*NW +: NW] = 16'd1001;
    req_valid[0] = 1'b1;
    applyStimulus(0, 0, 1'b1);

    $display("[TB] cache hit on n=1000");
    req_n[2*NW +: NW] = 16'd1000;
    req_valid[2] = 1'b1;
    applyStimulus(2, 0, 1'b1);
    check("n1000_prime", rsp_prime, 32'd7919);
    req_n[3*NW +: NW] = 16'd1000;
    req_valid[3] = 1'b1;
    applyStimulus(3, 0, 1'b1);

    $display("[TB] fairness with all requesters active");
    req_n[0*NW +: NW] = 16'd10;
    req_n[1*NW +: NW] = 16'd20;
    req_n[2*NW +: NW] = 16'd1000;
    req_n[3*NW +: NW] = 16'd3;
    req_valid = '1;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);
    applyStimulus(2, 5, 1'b0);
    applyStimulus(3, 0, 1'b0);
    applyStimulus(0, 0, 1'b1);
    req_valid = '0;

    $display("[TB] reset during engine wait");
    eng_lat = 10;
    req_n[3*NW +: NW] = 16'd7;
    req_valid[3] = 1'b1;
    @(negedge clk);
    req_valid[3] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_reset_busy", 32'(sched_busy), 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    jobs_model = 0;
    mc_valid   = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    bad = 1'b0;
    repeat (14) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== '0 || sched_busy !== 1'b0) bad = 1'b1;
    end
    check("stale_done_ignored", 32'(bad), 32'd0);
    eng_lat = 3;
    req_n[0*NW +: NW] = 16'd5;
    req_n[1*NW +: NW] = 16'd6;
    req_valid[1:0] = 2'b11;
    applyStimulus(0, 0, 1'b1);
    applyStimulus(1, 0, 1'b1);

`ifdef PRIME_SCHED_TIMEOUT_EN
    $display("[TB] engine timeout");
    engine_mute   = 1'b1;
    model_timeout = 1'b1;
    abort_at      = -1;
    req_n[2*NW +: NW] = 16'd50;
    req_valid[2] = 1'b1;
    applyStimulus(2, 0, 1'b1);
    check("abort_cycle", 32'(abort_at), 32'd20);
    engine_mute   = 1'b0;
    model_timeout = 1'b0;
    req_n[2*NW +: NW] = 16'd5;
    req_valid[2] = 1'b1;
    applyStimulus(2, 0, 1'b1);
    check("n5_prime", rsp_prime, 32'd11);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
